// File: rtl/rans_pkg.sv
// rans_pkg: shared constants and types for the rANS stream decoder.
//   STATE_WIDTH - width of the rANS state register x
//   RANS_L      - lower renormalisation bound; also the required final state
//   io_width()  - encoded word width for a given symbol width
//   dec_state_t - decoder FSM encoding
package rans_pkg;

  localparam int unsigned STATE_WIDTH = 32;
  localparam logic [STATE_WIDTH-1:0] RANS_L = 32'h0001_0000;

  function automatic int unsigned io_width(input int unsigned symbol_width);
    return 2 * symbol_width;
  endfunction

  typedef enum logic [3:0] {
    IDLE,
    INIT_HI,
    INIT_LO,
    LOOKUP,
    FETCH,
    UPDATE,
    RENORM,
    EMIT,
    CHECK
  } dec_state_t;

endpackage

// File: rtl/rans_decoder_stream_if.sv
// rans_decoder_stream_if: word-in / symbol-out streaming handshakes.
//   word_i, word_valid_i, word_ready_o   - encoded word stream into the decoder
//   symb_o, symb_valid_o, symb_ready_i   - decoded symbol stream out of the decoder
// Modports: slave = decoder side, master = host/producer side.
interface rans_decoder_stream_if #(
  parameter int unsigned SYMBOL_WIDTH = 8
) ();

  localparam int unsigned WORD_WIDTH = rans_pkg::io_width(SYMBOL_WIDTH);

  logic [WORD_WIDTH-1:0]   word_i;
  logic                    word_valid_i;
  logic                    word_ready_o;
  logic [SYMBOL_WIDTH-1:0] symb_o;
  logic                    symb_valid_o;
  logic                    symb_ready_i;

  modport slave (
    input  word_i, word_valid_i, symb_ready_i,
    output word_ready_o, symb_o, symb_valid_o
  );

  modport master (
    output word_i, word_valid_i, symb_ready_i,
    input  word_ready_o, symb_o, symb_valid_o
  );

endinterface

// File: rtl/rans_dec_tables.sv
// rans_dec_tables: decoder lookup RAMs, not reset, registered reads.
//   slot table : slot index -> symbol (2**RESOLUTION entries)
//   freq table : symbol -> {freq, cum} (2**SYMBOL_WIDTH entries)
//   *_wr_i / *_waddr_i / *_w*_i : write ports
//   *_rd_i / *_raddr_i          : read strobes; data appears the next cycle
//                                 and holds until the next strobe
module rans_dec_tables #(
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    slot_wr_i,
  input  logic [RESOLUTION-1:0]   slot_waddr_i,
  input  logic [SYMBOL_WIDTH-1:0] slot_wsymb_i,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] freq_waddr_i,
  input  logic [RESOLUTION:0]     freq_wdata_i,
  input  logic [RESOLUTION-1:0]   cum_wdata_i,
  input  logic                    slot_rd_i,
  input  logic [RESOLUTION-1:0]   slot_raddr_i,
  input  logic                    freq_rd_i,
  input  logic [SYMBOL_WIDTH-1:0] freq_raddr_i,
  output logic [SYMBOL_WIDTH-1:0] slot_symb_o,
  output logic [RESOLUTION:0]     freq_o,
  output logic [RESOLUTION-1:0]   cum_o
);

  logic [SYMBOL_WIDTH-1:0] slot_mem [0:(1 << RESOLUTION)-1];
  logic [2*RESOLUTION:0]   freq_mem [0:(1 << SYMBOL_WIDTH)-1];

  logic [SYMBOL_WIDTH-1:0] slot_symb_q, slot_symb_d;
  logic [2*RESOLUTION:0]   freq_cum_q, freq_cum_d;

  always_comb begin
    slot_symb_d = slot_symb_q;
    freq_cum_d  = freq_cum_q;
    if (slot_rd_i) slot_symb_d = slot_mem[slot_raddr_i];
    if (freq_rd_i) freq_cum_d  = freq_mem[freq_raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (slot_wr_i) slot_mem[slot_waddr_i] <= slot_wsymb_i;
    if (freq_wr_i) freq_mem[freq_waddr_i] <= {freq_wdata_i, cum_wdata_i};
    slot_symb_q <= slot_symb_d;
    freq_cum_q  <= freq_cum_d;
  end

  assign slot_symb_o = slot_symb_q;
  assign freq_o      = freq_cum_q[2*RESOLUTION:RESOLUTION];
  assign cum_o       = freq_cum_q[RESOLUTION-1:0];

endmodule

// File: rtl/rans_decoder_stream.sv
// rans_decoder_stream: single-stream rANS decoder.
//   clk_i, rst_i               - clock, async active-high reset
//   freq_wr_i/freq_addr_i/...  - freq/cum table write (IDLE only)
//   slot_wr_i/slot_addr_i/...  - slot->symbol table write (IDLE only)
//   start_i, num_symb_i        - begin decoding num_symb_i symbols (IDLE only)
//   strm                       - word input and symbol output handshakes
//   busy_o                     - high in every state except IDLE
//   done_o                     - one-cycle pulse at end of decode
//   err_o                      - final state != RANS_L, held until next start
// Words arrive in decode order: final encoder state first (high, then low).
module rans_decoder_stream
  import rans_pkg::*;
#(
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
  input  logic [RESOLUTION:0]     freq_i,
  input  logic [RESOLUTION-1:0]   cum_freq_i,
  input  logic                    slot_wr_i,
  input  logic [RESOLUTION-1:0]   slot_addr_i,
  input  logic [SYMBOL_WIDTH-1:0] slot_symb_i,
  input  logic                    start_i,
  input  logic [CNT_WIDTH-1:0]    num_symb_i,
  rans_decoder_stream_if.slave    strm,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned WORD_WIDTH = io_width(SYMBOL_WIDTH);

  dec_state_t              state_q, state_d;
  logic [STATE_WIDTH-1:0]  x_q, x_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SYMBOL_WIDTH-1:0] symb_q, symb_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;

  logic                    idle;
  logic                    word_xfer;
  logic                    slot_rd, freq_rd;
  logic [SYMBOL_WIDTH-1:0] tbl_symb;
  logic [RESOLUTION:0]     tbl_freq;
  logic [RESOLUTION-1:0]   tbl_cum;
  logic [STATE_WIDTH-1:0]  x_upd;

  assign idle      = (state_q == IDLE);
  assign word_xfer = strm.word_valid_i && strm.word_ready_o;

  rans_dec_tables #(
    .RESOLUTION   (RESOLUTION),
    .SYMBOL_WIDTH (SYMBOL_WIDTH)
  ) u_tables (
    .clk_i        (clk_i),
    .slot_wr_i    (slot_wr_i && idle),
    .slot_waddr_i (slot_addr_i),
    .slot_wsymb_i (slot_symb_i),
    .freq_wr_i    (freq_wr_i && idle),
    .freq_waddr_i (freq_addr_i),
    .freq_wdata_i (freq_i),
    .cum_wdata_i  (cum_freq_i),
    .slot_rd_i    (slot_rd),
    .slot_raddr_i (x_q[RESOLUTION-1:0]),
    .freq_rd_i    (freq_rd),
    .freq_raddr_i (tbl_symb),
    .slot_symb_o  (tbl_symb),
    .freq_o       (tbl_freq),
    .cum_o        (tbl_cum)
  );

  // x is unchanged since LOOKUP, so its low bits are still the slot.
  assign x_upd = STATE_WIDTH'(tbl_freq) * (x_q >> RESOLUTION)
               + STATE_WIDTH'(x_q[RESOLUTION-1:0])
               - STATE_WIDTH'(tbl_cum);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    symb_d  = symb_q;
    err_d   = err_q;
    done_d  = 1'b0;
    slot_rd = 1'b0;
    freq_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = num_symb_i;
          err_d   = 1'b0;
          state_d = INIT_HI;
        end
      end
      INIT_HI: begin
        if (word_xfer) begin
          x_d[STATE_WIDTH-1 -: WORD_WIDTH] = strm.word_i;
          state_d = INIT_LO;
        end
      end
      INIT_LO: begin
        if (word_xfer) begin
          x_d[WORD_WIDTH-1:0] = strm.word_i;
          state_d = (cnt_q == '0) ? CHECK : LOOKUP;
        end
      end
      LOOKUP: begin
        slot_rd = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        symb_d  = tbl_symb;
        freq_rd = 1'b1;
        state_d = UPDATE;
      end
      UPDATE: begin
        x_d     = x_upd;
        cnt_d   = cnt_q - CNT_WIDTH'(1);
        state_d = (x_upd < RANS_L) ? RENORM : EMIT;
      end
      RENORM: begin
        if (word_xfer) begin
          x_d     = {x_q[STATE_WIDTH-WORD_WIDTH-1:0], strm.word_i};
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (strm.symb_ready_i) state_d = (cnt_q == '0) ? CHECK : LOOKUP;
      end
      CHECK: begin
        // err and done are registered together so err is valid whenever done is seen.
        err_d   = (x_q != RANS_L);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      symb_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      symb_q  <= symb_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign strm.word_ready_o = (state_q == INIT_HI) || (state_q == INIT_LO) || (state_q == RENORM);
  assign strm.symb_valid_o = (state_q == EMIT);
  assign strm.symb_o       = symb_q;
  assign busy_o            = !idle;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_rans_decoder_stream.sv
// tb_rans_decoder_stream: directed self-checking bench for rans_decoder_stream.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_rans_decoder_stream;
  import rans_pkg::*;

  localparam int unsigned RES = 10;
  localparam int unsigned SW  = 8;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          freq_wr = 1'b0;
  logic [SW-1:0] freq_addr = '0;
  logic [RES:0]  freq = '0;
  logic [RES-1:0] cum_freq = '0;
  logic          slot_wr = 1'b0;
  logic [RES-1:0] slot_addr = '0;
  logic [SW-1:0] slot_symb = '0;
  logic          start = 1'b0;
  logic [CW-1:0] num_symb = '0;
  logic          busy, done, err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rans_decoder_stream_if #(.SYMBOL_WIDTH(SW)) strm ();

  rans_decoder_stream #(
    .RESOLUTION   (RES),
    .SYMBOL_WIDTH (SW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .freq_wr_i   (freq_wr),
    .freq_addr_i (freq_addr),
    .freq_i      (freq),
    .cum_freq_i  (cum_freq),
    .slot_wr_i   (slot_wr),
    .slot_addr_i (slot_addr),
    .slot_symb_i (slot_symb),
    .start_i     (start),
    .num_symb_i  (num_symb),
    .strm        (strm),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  // ---------------- stimulus helpers (entered and left on a falling edge) ----

  task automatic write_freq(input int unsigned s, input int unsigned f, input int unsigned c);
    freq_wr = 1'b1; freq_addr = SW'(s); freq = (RES+1)'(f); cum_freq = RES'(c);
    @(negedge clk);
    freq_wr = 1'b0;
  endtask

  // Slot i belongs to symbol 0 when i < split, otherwise to symbol 1.
  task automatic write_slots(input int unsigned split);
    for (int unsigned i = 0; i < (1 << RES); i++) begin
      slot_wr = 1'b1; slot_addr = RES'(i); slot_symb = (i < split) ? 8'd0 : 8'd1;
      @(negedge clk);
    end
    slot_wr = 1'b0;
  endtask

  task automatic load_uniform();
    write_freq(0, 512, 0);
    write_freq(1, 512, 512);
    write_slots(512);
  endtask

  task automatic load_skew();
    write_freq(0, 1, 0);
    write_freq(1, 1023, 1);
    write_slots(1);
  endtask

  task automatic start_decode(input int unsigned n);
    start = 1'b1; num_symb = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w, output bit ok);
    ok = 1'b0;
    strm.word_i = w; strm.word_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (strm.word_ready_o === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    strm.word_valid_i = 1'b0;
  endtask

  task automatic pop_symb(output logic [SW-1:0] s, output bit ok);
    ok = 1'b0; s = 'x;
    strm.symb_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (strm.symb_valid_o === 1'b1) begin
        s = strm.symb_o; ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    strm.symb_ready_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output logic e);
    ok = 1'b0; e = 'x;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1; e = err;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------------------------------------------

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, err, strm.word_ready_o, strm.symb_valid_o} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got {busy,done,err,wrdy,svld}=%b required 00000",
               {busy, done, err, strm.word_ready_o, strm.symb_valid_o});
    end
    tests_run++;
    if (strm.symb_o !== 8'h00) begin
      tests_failed++; $display("FAIL reset_symb: got %0h required 0", strm.symb_o);
    end
    tests_run++;
    if (dut.x_q !== 32'h0) begin
      tests_failed++; $display("FAIL reset_x: got %0h required 0", dut.x_q);
    end
    tests_run++;
    if (dut.cnt_q !== 16'h0) begin
      tests_failed++; $display("FAIL reset_cnt: got %0h required 0", dut.cnt_q);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Uniform tables, words 0x0004 0x0200: symbols 1 then 0, final x = 0x10000.
  task automatic test_no_renorm(input string tag);
    bit ok; logic [SW-1:0] s; logic e;
    start_decode(2);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL %s busy: got %b required 1", tag, busy);
    end
    push_word(16'h0004, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL %s word_hi: got no ready required ready", tag); end
    push_word(16'h0200, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL %s word_lo: got no ready required ready", tag); end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd1) begin tests_failed++; $display("FAIL %s sym_a: got %0h required 1", tag, s); end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd0) begin tests_failed++; $display("FAIL %s sym_b: got %0h required 0", tag, s); end
    wait_done(ok, e);
    tests_run++;
    if (!ok || e !== 1'b0) begin tests_failed++; $display("FAIL %s done_err: got done=%b err=%b required done=1 err=0", tag, ok, e); end
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL %s after_done: got done=%b busy=%b required 0 0", tag, done, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok; bit seen; logic [SW-1:0] s; logic e;
    start_decode(2);
    push_word(16'h0004, ok);
    push_word(16'h0200, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL bp_words: got no ready required ready"); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (strm.symb_valid_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got no symb_valid required symb_valid"); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (strm.symb_valid_o !== 1'b1 || strm.symb_o !== 8'd1) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got valid=%b symb=%0h required valid=1 symb=1", i, strm.symb_valid_o, strm.symb_o);
      end
      @(negedge clk);
    end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd1) begin tests_failed++; $display("FAIL bp_sym_a: got %0h required 1", s); end
    tests_run++;
    if (strm.symb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL bp_early: got valid=%b required 0", strm.symb_valid_o); end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd0) begin tests_failed++; $display("FAIL bp_sym_b: got %0h required 0", s); end
    wait_done(ok, e);
    tests_run++;
    if (!ok || e !== 1'b0) begin tests_failed++; $display("FAIL bp_done: got done=%b err=%b required done=1 err=0", ok, e); end
  endtask

  task automatic test_control_misuse();
    bit ok; logic [SW-1:0] s; logic e;
    start_decode(2);
    push_word(16'h0004, ok);
    start = 1'b1; num_symb = 16'd5;
    freq_wr = 1'b1; freq_addr = 8'd1; freq = 11'd7; cum_freq = 10'd3;
    slot_wr = 1'b1; slot_addr = 10'd512; slot_symb = 8'd0;
    repeat (3) @(negedge clk);
    start = 1'b0; freq_wr = 1'b0; slot_wr = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || strm.word_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL mis_state: got busy=%b wrdy=%b required 1 1", busy, strm.word_ready_o);
    end
    push_word(16'h0200, ok);
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd1) begin tests_failed++; $display("FAIL mis_sym_a: got %0h required 1", s); end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd0) begin tests_failed++; $display("FAIL mis_sym_b: got %0h required 0", s); end
    wait_done(ok, e);
    tests_run++;
    if (!ok || e !== 1'b0) begin tests_failed++; $display("FAIL mis_done: got done=%b err=%b required done=1 err=0", ok, e); end
  endtask

  task automatic test_async_reset();
    bit ok; bit seen; logic [SW-1:0] s;
    start_decode(2);
    push_word(16'h0004, ok);
    push_word(16'h0200, ok);
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd1) begin tests_failed++; $display("FAIL ar_sym_a: got %0h required 1", s); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dut.state_q == FETCH) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b1) begin tests_failed++; $display("FAIL ar_fetch: got no FETCH required FETCH"); end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, err, strm.word_ready_o, strm.symb_valid_o} !== 5'b0 || strm.symb_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL ar_outputs: got {busy,done,err,wrdy,svld}=%b symb=%0h required 00000 symb=0",
               {busy, done, err, strm.word_ready_o, strm.symb_valid_o}, strm.symb_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_no_renorm("post_reset");
  endtask

  // Skewed tables, words 0x0001 0x0400: x drops to 65, renorm with 0xBEEF.
  task automatic test_renorm();
    bit ok; bit seen; logic [SW-1:0] s; logic e;
    start_decode(1);
    push_word(16'h0001, ok);
    push_word(16'h0400, ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (strm.word_ready_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b1 || dut.x_q !== 32'd65) begin
      tests_failed++; $display("FAIL rn_enter: got ready=%b x=%0h required ready=1 x=41", seen, dut.x_q);
    end
    push_word(16'hBEEF, ok);
    tests_run++;
    if (!ok || dut.x_q !== 32'h0041_BEEF) begin
      tests_failed++; $display("FAIL rn_x: got %0h required 41beef", dut.x_q);
    end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd0) begin tests_failed++; $display("FAIL rn_sym: got %0h required 0", s); end
    wait_done(ok, e);
    tests_run++;
    if (!ok || e !== 1'b1) begin tests_failed++; $display("FAIL rn_err: got done=%b err=%b required done=1 err=1", ok, e); end
  endtask

  task automatic test_word_stall();
    bit ok; bit seen; logic [SW-1:0] s; logic e;
    start_decode(1);
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL ws_errclr: got %b required 0", err); end
    push_word(16'h0001, ok);
    push_word(16'h0400, ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (strm.word_ready_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (!seen || strm.word_ready_o !== 1'b1 || dut.state_q != RENORM || dut.x_q !== 32'd65) begin
        tests_failed++;
        $display("FAIL ws_hold%0d: got wrdy=%b x=%0h required wrdy=1 x=41 in RENORM", i, strm.word_ready_o, dut.x_q);
      end
      @(negedge clk);
    end
    push_word(16'hBEEF, ok);
    tests_run++;
    if (!ok || dut.x_q !== 32'h0041_BEEF || strm.symb_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL ws_x: got x=%0h valid=%b required x=41beef valid=1", dut.x_q, strm.symb_valid_o);
    end
    pop_symb(s, ok);
    tests_run++;
    if (!ok || s !== 8'd0) begin tests_failed++; $display("FAIL ws_sym: got %0h required 0", s); end
    wait_done(ok, e);
    tests_run++;
    if (!ok || e !== 1'b1) begin tests_failed++; $display("FAIL ws_err: got done=%b err=%b required done=1 err=1", ok, e); end
  endtask

  initial begin
    strm.word_i = '0;
    strm.word_valid_i = 1'b0;
    strm.symb_ready_i = 1'b0;
    test_reset();
    load_uniform();
    test_no_renorm("no_renorm");
    test_backpressure();
    test_control_misuse();
    test_async_reset();
    load_skew();
    test_renorm();
    test_word_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    tests_failed++;
    $display("FAIL watchdog: got time limit reached required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rans_decoder_stream.md
Name: rans_decoder_stream

Overview:
- Single-stream rANS decoder: the receive-side counterpart of the rANS encoder stream.
- Consumes 16-bit encoded words (2*SYMBOL_WIDTH) and emits decoded symbols with valid/ready backpressure.
- Host loads the frequency/cumulative-frequency table and a slot->symbol table before start; the word stream must be presented in decode order (reverse of encode emission: final state first).
- Final-state check flags stream corruption.

Parameters:
- RESOLUTION, 10, log2 of total frequency M (slot width).
- SYMBOL_WIDTH, 8, symbol width; encoded word width = 2*SYMBOL_WIDTH.
- CNT_WIDTH, 16, width of the symbol-count input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- freq_wr_i  in  1  write freq/cum entry.
- freq_addr_i  in  SYMBOL_WIDTH  symbol index for the freq/cum write.
- freq_i  in  RESOLUTION+1  symbol frequency (1..M).
- cum_freq_i  in  RESOLUTION  cumulative frequency.
- slot_wr_i  in  1  write slot table entry.
- slot_addr_i  in  RESOLUTION  slot index.
- slot_symb_i  in  SYMBOL_WIDTH  symbol owning the slot.
- start_i  in  1  begin decode; latches num_symb_i.
- num_symb_i  in  CNT_WIDTH  number of symbols to decode.
- word_i  in  2*SYMBOL_WIDTH  encoded word.
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  decoder accepts word_i.
- symb_o  out  SYMBOL_WIDTH  decoded symbol.
- symb_valid_o  out  1  symb_o valid.
- symb_ready_i  in  1  downstream accepts symb_o.
- busy_o  out  1  decode in progress.
- done_o  out  1  one-cycle pulse at end of decode.
- err_o  out  1  final state != L; held until the next start_i.

Behaviour:
- Clocking/reset: one clock, clk_i; rst_i is asynchronous, active-high.
- Reset values:
  - FSM=IDLE.
  - word_ready_o, symb_valid_o, busy_o, done_o, err_o = 0.
  - symb_o=0; state x=0; counter=0.
  - Table RAMs are not reset and retain their contents.
- Constants: STATE_WIDTH=32, L=2^16, M=2^RESOLUTION.
- Table writes are accepted only in IDLE and ignored otherwise. Reads are synchronous (1-cycle registered).
- start_i is honoured only in IDLE; ignored while busy_o=1. On start: latch count, clear err_o, go to INIT_HI.
- Word handshake: a transfer occurs when word_valid_i && word_ready_o. word_ready_o=1 only in INIT_HI, INIT_LO and RENORM.
- FSM:
  - IDLE -> INIT_HI (start_i).
  - INIT_HI: x[31:16] <= word -> INIT_LO.
  - INIT_LO: x[15:0] <= word -> LOOKUP, or CHECK if count==0.
  - LOOKUP: slot = x[RESOLUTION-1:0]; issue slot-table read -> FETCH.
  - FETCH: symbol registered; issue freq/cum read -> UPDATE.
  - UPDATE: x <= freq*(x>>RESOLUTION) + slot - cum, computed at 32 bits, upper product bits discarded. Decrement count. -> RENORM if the new x < L, else EMIT.
  - RENORM: on transfer, x <= {x[15:0], word} -> EMIT. At most one renorm per symbol (guaranteed since freq>=1 and L=2^16).
  - EMIT: symb_valid_o=1 holding the symbol. On symb_ready_i: go to CHECK if count==0, else LOOKUP.
  - CHECK: err_o <= (x != L); done_o pulse 1 cycle -> IDLE.
- Per-symbol latency: 4 cycles (no renorm, no stall); RENORM and backpressure add stall cycles only.
- symb_o and symb_valid_o are stable while stalled.
- busy_o=1 in every state except IDLE.
- Reset mid-operation: immediate return to IDLE with outputs at reset values; the partial stream is discarded.

Decomposition:
- Package rans_pkg:
  - STATE_WIDTH, RANS_L, IO word width function.
  - typedef enum dec_state_t {IDLE, INIT_HI, INIT_LO, LOOKUP, FETCH, UPDATE, RENORM, EMIT, CHECK}.
- Sub-module rans_dec_tables: dual RAMs (slot->symbol; symbol->{freq,cum}) with write ports and registered reads.

Test Plan:
- No renorm: RES=10; sym0 freq=512 cum=0, sym1 freq=512 cum=512; slots 0..511->0, 512..1023->1. Words 0x0004, 0x0200; num=2. -> symbols 1 then 0; done_o pulse; err_o=0 (x returns to 0x10000).
- Renorm: sym0 freq=1 cum=0 (slot 0); sym1 freq=1023 cum=1. Init 0x0001, 0x0400; num=1. -> symbol 0. Intermediate x=65 triggers RENORM, word_ready_o=1. Feed 0xBEEF -> x=0x0041BEEF; err_o=1 at CHECK.
- Backpressure: repeat test 1 with symb_ready_i low for 5 cycles at the first EMIT. -> symb_o=1 held stable; the second symbol is not emitted early; same final result.
- Word stall: test 2 with word_valid_i low for 3 cycles in RENORM. -> FSM holds, no spurious state change; x still 0x0041BEEF.
- Control misuse: start_i and freq_wr_i asserted mid-decode of test 1. -> ignored (tables and count unchanged); outputs match test 1.
- Async reset asserted during FETCH. -> all outputs 0 immediately; a subsequent test-1 run passes using the retained tables.
